// File: rtl/usb_rw_pkg.sv
// Shared types and helpers for the USB burst read/write sequencer.
package usb_rw_pkg;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_SETUP_START = 3'd1,
        ST_SETUP_WAIT  = 3'd2,
        ST_DATA_FETCH  = 3'd3,
        ST_DATA_START  = 3'd4,
        ST_DATA_WAIT   = 3'd5,
        ST_DONE        = 3'd6
    } state_e;

    localparam logic [6:0] DEFAULT_DEV_ADDR   = 7'd5;
    localparam logic [3:0] DEFAULT_SETUP_ENDP = 4'd4;
    localparam logic [3:0] DEFAULT_DATA_ENDP  = 4'd8;

    // Setup payload is always {len, addr}; it never exceeds one 64-bit word.
    localparam int SETUP_W = 64;

    function automatic logic [SETUP_W-1:0] pack_setup(
        input logic [SETUP_W-1:0] len_ext,
        input logic [SETUP_W-1:0] addr_ext,
        input int unsigned        addr_w
    );
        return (len_ext << addr_w) | addr_ext;
    endfunction

endpackage

// File: rtl/usb_rw_retry_ctr.sv
// Saturating per-transaction retry counter; flags when no retries remain.
module usb_rw_retry_ctr #(
    parameter int MAX_RETRY = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic exhausted
);
    localparam int CNT_W = ($clog2(MAX_RETRY + 1) > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_RETRY);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins, increment stops at the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign exhausted = (cnt_q == CNT_MAX);

endmodule

// File: rtl/usb_rw_burst_seq.sv
// Burst read/write sequencer: one setup OUT then one IN/OUT per data word,
// with automatic retry of failed transactions.
module usb_rw_burst_seq
    import usb_rw_pkg::*;
#(
    parameter int         DATA_W     = 64,
    parameter int         ADDR_W     = 16,
    parameter int         BURST_MAX  = 4,
    parameter int         MAX_RETRY  = 3,
    parameter logic [6:0] DEV_ADDR   = DEFAULT_DEV_ADDR,
    parameter logic [3:0] SETUP_ENDP = DEFAULT_SETUP_ENDP,
    parameter logic [3:0] DATA_ENDP  = DEFAULT_DATA_ENDP,
    localparam int        LEN_W      = $clog2(BURST_MAX)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_read,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              done,
    output logic              cancel,
    output logic              pro_start,
    output logic              pro_in,
    output logic [6:0]        pro_addr,
    output logic [3:0]        pro_endp,
    output logic [DATA_W-1:0] pro_data_down,
    input  logic              pro_free,
    input  logic              pro_bad,
    input  logic              pro_recv_ready,
    input  logic [DATA_W-1:0] pro_data_up
);

    state_e              state_q, state_d;
    logic                read_q, read_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    word_cnt_q, word_cnt_d;
    logic                fail_q, fail_d;
    logic                wait_first_q, wait_first_d;
    logic [DATA_W-1:0]   wbuf_q, wbuf_d;
    logic [DATA_W-1:0]   rbuf_q, rbuf_d;
    logic                rd_valid_q, rd_valid_d;

    logic                retry_clr_s;
    logic                retry_inc_s;
    logic                retry_exhausted_s;
    logic [SETUP_W-1:0]  setup_s;

    usb_rw_retry_ctr #(
        .MAX_RETRY (MAX_RETRY)
    ) u_retry (
        .clk       (clk),
        .rst       (rst),
        .clr       (retry_clr_s),
        .inc       (retry_inc_s),
        .exhausted (retry_exhausted_s)
    );

    assign setup_s = pack_setup(SETUP_W'(len_q), SETUP_W'(addr_q), ADDR_W);

    // Next-state logic; the first wait cycle after pro_start is blind to free/bad.
    always_comb begin
        state_d      = state_q;
        read_d       = read_q;
        addr_d       = addr_q;
        len_d        = len_q;
        word_cnt_d   = word_cnt_q;
        fail_d       = fail_q;
        wait_first_d = 1'b0;
        wbuf_d       = wbuf_q;
        rbuf_d       = rbuf_q;
        rd_valid_d   = 1'b0;
        retry_clr_s  = 1'b0;
        retry_inc_s  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    read_d      = req_read;
                    addr_d      = req_addr;
                    len_d       = req_len;
                    word_cnt_d  = '0;
                    fail_d      = 1'b0;
                    retry_clr_s = 1'b1;
                    state_d     = ST_SETUP_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP_START: begin
                wait_first_d = 1'b1;
                state_d      = ST_SETUP_WAIT;
            end
            ST_SETUP_WAIT: begin
                if (wait_first_q) begin
                    state_d = ST_SETUP_WAIT;
                end else if (pro_bad) begin
                    if (retry_exhausted_s) begin
                        fail_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        retry_inc_s = 1'b1;
                        state_d     = ST_SETUP_START;
                    end
                end else if (pro_free) begin
                    retry_clr_s = 1'b1;
                    state_d     = read_q ? ST_DATA_START : ST_DATA_FETCH;
                end else begin
                    state_d = ST_SETUP_WAIT;
                end
            end
            ST_DATA_FETCH: begin
                if (wr_valid) begin
                    wbuf_d  = wr_data;
                    state_d = ST_DATA_START;
                end else begin
                    state_d = ST_DATA_FETCH;
                end
            end
            ST_DATA_START: begin
                wait_first_d = 1'b1;
                state_d      = ST_DATA_WAIT;
            end
            ST_DATA_WAIT: begin
                if (read_q && pro_recv_ready) begin
                    rbuf_d = pro_data_up;
                end else begin
                    rbuf_d = rbuf_q;
                end
                if (wait_first_q) begin
                    state_d = ST_DATA_WAIT;
                end else if (pro_bad) begin
                    if (retry_exhausted_s) begin
                        fail_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        retry_inc_s = 1'b1;
                        state_d     = ST_DATA_START;
                    end
                end else if (pro_free) begin
                    retry_clr_s = 1'b1;
                    rd_valid_d  = read_q;
                    if (word_cnt_q == len_q) begin
                        state_d = ST_DONE;
                    end else begin
                        word_cnt_d = word_cnt_q + {{(LEN_W-1){1'b0}}, 1'b1};
                        state_d    = read_q ? ST_DATA_START : ST_DATA_FETCH;
                    end
                end else begin
                    state_d = ST_DATA_WAIT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            read_q       <= 1'b0;
            addr_q       <= '0;
            len_q        <= '0;
            word_cnt_q   <= '0;
            fail_q       <= 1'b0;
            wait_first_q <= 1'b0;
            wbuf_q       <= '0;
            rbuf_q       <= '0;
            rd_valid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            read_q       <= read_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            word_cnt_q   <= word_cnt_d;
            fail_q       <= fail_d;
            wait_first_q <= wait_first_d;
            wbuf_q       <= wbuf_d;
            rbuf_q       <= rbuf_d;
            rd_valid_q   <= rd_valid_d;
        end
    end

    // Outputs decoded from state and registered fields only.
    always_comb begin
        req_ready     = 1'b0;
        wr_ready      = 1'b0;
        done          = 1'b0;
        cancel        = 1'b0;
        pro_start     = 1'b0;
        pro_in        = 1'b0;
        pro_addr      = 7'd0;
        pro_endp      = 4'd0;
        pro_data_down = '0;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
            end
            ST_SETUP_START, ST_SETUP_WAIT: begin
                pro_start     = (state_q == ST_SETUP_START);
                pro_addr      = DEV_ADDR;
                pro_endp      = SETUP_ENDP;
                pro_data_down = DATA_W'(setup_s);
            end
            ST_DATA_FETCH: begin
                wr_ready = 1'b1;
            end
            ST_DATA_START, ST_DATA_WAIT: begin
                pro_start     = (state_q == ST_DATA_START);
                pro_in        = read_q;
                pro_addr      = DEV_ADDR;
                pro_endp      = DATA_ENDP;
                pro_data_down = read_q ? '0 : wbuf_q;
            end
            ST_DONE: begin
                done   = 1'b1;
                cancel = fail_q;
            end
            default: begin
                req_ready = 1'b0;
            end
        endcase
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = rbuf_q;

endmodule
